// File: rtl/inst_buffer_pkg.sv
// Shared definitions for the fetch-to-decode instruction buffer.
package inst_buffer_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned EXC_W = 7;

  localparam logic [XLEN-1:0] INST_NOP_ENC = 32'h0340_0000;

  localparam logic [1:0] NR_NONE = 2'b00;
  localparam logic [1:0] NR_ONE  = 2'b01;
  localparam logic [1:0] NR_TWO  = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_next;
    logic [XLEN-1:0]  inst;
    logic [EXC_W-1:0] exc;
  } ibuf_entry_t;

  // Value driven on an output slot that holds no entry.
  localparam ibuf_entry_t IBUF_EMPTY_SLOT = '{
    pc:      32'h0000_0000,
    pc_next: 32'h0000_0004,
    inst:    INST_NOP_ENC,
    exc:     '0
  };

  // Slot-count encoding shared by in_valid and num_read; 2'b10 decodes to zero.
  function automatic logic [1:0] slot_count(input logic [1:0] enc);
    logic [1:0] n;
    n = 2'd0;
    case (enc)
      NR_ONE:  n = 2'd1;
      NR_TWO:  n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch-side push bus and decode-side pop bus of the instruction buffer.
interface inst_buffer_if;
  import inst_buffer_pkg::*;

  logic [1:0]       in_valid;
  logic [XLEN-1:0]  in_pc0;
  logic [XLEN-1:0]  in_pc_next0;
  logic [XLEN-1:0]  in_inst0;
  logic [EXC_W-1:0] in_exc0;
  logic [XLEN-1:0]  in_pc1;
  logic [XLEN-1:0]  in_pc_next1;
  logic [XLEN-1:0]  in_inst1;
  logic [EXC_W-1:0] in_exc1;
  logic             in_ready;

  logic [1:0]       out_valid;
  logic [XLEN-1:0]  out_pc0;
  logic [XLEN-1:0]  out_pc_next0;
  logic [XLEN-1:0]  out_inst0;
  logic [EXC_W-1:0] out_exc0;
  logic [XLEN-1:0]  out_pc1;
  logic [XLEN-1:0]  out_pc_next1;
  logic [XLEN-1:0]  out_inst1;
  logic [EXC_W-1:0] out_exc1;
  logic [1:0]       num_read;

  modport master (
    output in_valid, in_pc0, in_pc_next0, in_inst0, in_exc0,
           in_pc1, in_pc_next1, in_inst1, in_exc1, num_read,
    input  in_ready, out_valid, out_pc0, out_pc_next0, out_inst0, out_exc0,
           out_pc1, out_pc_next1, out_inst1, out_exc1
  );

  modport slave (
    input  in_valid, in_pc0, in_pc_next0, in_inst0, in_exc0,
           in_pc1, in_pc_next1, in_inst1, in_exc1, num_read,
    output in_ready, out_valid, out_pc0, out_pc_next0, out_inst0, out_exc0,
           out_pc1, out_pc_next1, out_inst1, out_exc1
  );

endinterface

// File: rtl/ibuf_mem.sv
// Instruction buffer storage: two write ports, two asynchronous read ports, no reset.
module ibuf_mem
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we0,
  input  logic [PTR_W-1:0] wa0,
  input  ibuf_entry_t      wd0,
  input  logic             we1,
  input  logic [PTR_W-1:0] wa1,
  input  ibuf_entry_t      wd1,
  input  logic [PTR_W-1:0] ra0,
  input  logic [PTR_W-1:0] ra1,
  output ibuf_entry_t      rd0,
  output ibuf_entry_t      rd1
);

  ibuf_entry_t mem [DEPTH];

  // wa0 and wa1 are always distinct (tail, tail+1), so port order is irrelevant.
  always_ff @(posedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];

endmodule

// File: rtl/inst_buffer.sv
// Circular instruction queue between fetch and decode: push 0-2, pop 0-2 per cycle.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  inst_buffer_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             ready;
  logic [1:0]       push_n;
  logic [1:0]       pop_raw;
  logic [1:0]       pop_n;
  logic             we0;
  logic             we1;
  ibuf_entry_t      wd0;
  ibuf_entry_t      wd1;
  ibuf_entry_t      rd0;
  ibuf_entry_t      rd1;
  ibuf_entry_t      slot0;
  ibuf_entry_t      slot1;

  // Ready uses only the registered count so it stays off the issue-to-fetch path.
  assign ready   = (CNT_W'(DEPTH) - count) >= CNT_W'(2);
  assign push_n  = ready ? slot_count(bus.in_valid) : 2'd0;
  assign pop_raw = slot_count(bus.num_read);
  assign pop_n   = (CNT_W'(pop_raw) > count) ? 2'(count) : pop_raw;

  assign we0 = !rst && !flush && (push_n != 2'd0);
  assign we1 = !rst && !flush && (push_n == 2'd2);
  assign wd0 = '{pc: bus.in_pc0, pc_next: bus.in_pc_next0, inst: bus.in_inst0, exc: bus.in_exc0};
  assign wd1 = '{pc: bus.in_pc1, pc_next: bus.in_pc_next1, inst: bus.in_inst1, exc: bus.in_exc1};

  ibuf_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clk (clk),
    .we0 (we0),
    .wa0 (tail),
    .wd0 (wd0),
    .we1 (we1),
    .wa1 (tail + PTR_W'(1)),
    .wd1 (wd1),
    .ra0 (head),
    .ra1 (head + PTR_W'(1)),
    .rd0 (rd0),
    .rd1 (rd1)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_n);
      tail  <= tail + PTR_W'(push_n);
      count <= count + CNT_W'(push_n) - CNT_W'(pop_n);
    end
  end

  assign slot0 = (count != '0)        ? rd0 : IBUF_EMPTY_SLOT;
  assign slot1 = (count > CNT_W'(1))  ? rd1 : IBUF_EMPTY_SLOT;

  assign bus.in_ready     = ready;
  assign bus.out_valid    = {count > CNT_W'(1), count != '0};
  assign bus.out_pc0      = slot0.pc;
  assign bus.out_pc_next0 = slot0.pc_next;
  assign bus.out_inst0    = slot0.inst;
  assign bus.out_exc0     = slot0.exc;
  assign bus.out_pc1      = slot1.pc;
  assign bus.out_pc_next1 = slot1.pc_next;
  assign bus.out_inst1    = slot1.inst;
  assign bus.out_exc1     = slot1.exc;

  a_in_valid_legal: assert property (@(posedge clk) disable iff (rst) bus.in_valid != 2'b10)
    else $error("inst_buffer: illegal in_valid 2'b10");
  a_num_read_legal: assert property (@(posedge clk) disable iff (rst) bus.num_read != 2'b10)
    else $error("inst_buffer: illegal num_read 2'b10");
  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH))
    else $error("inst_buffer: count exceeds depth");

endmodule
